sipo_shift_sched: RTL
=====================

Name: sipo_shift_sched

Overview:
- Controller that owns a WIDTH-bit serial-in/parallel-out shift register and shares it between two requesters.
- Accepts a parallel word from either requester over a valid/ready handshake, with round-robin arbitration.
- Clears the register, then drives its serial input and a one-cycle shift strobe at a programmable tick rate. The strobe replaces the free-running 1 Hz enable.
- Signals completion when the register's parallel output holds the requested word.

Parameters:
- WIDTH, 4: shift register width, bits per word.
- TICK_DIV, 100_000_000: clk cycles between shift strobes; must be >= 1.
- CNT_W, 27: tick counter width; must satisfy 2^CNT_W > TICK_DIV-1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 holds a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word is accepted this cycle.
- req1_valid  in  1  requester 1 holds a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word is accepted this cycle.
- hold  in  1  freezes the tick counter while high.
- sr_clr  out  1  one-cycle synchronous clear to the shift register.
- sr_shift  out  1  one-cycle shift strobe; the register does {sr_si, reg[WIDTH-1:1]}.
- sr_si  out  1  serial bit, valid when sr_shift=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: the word is complete in the register.
- done_src  out  1  requester id of the completed word; valid while done=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, tick counter=0, bit index=0, hold register=0.
  - Round-robin pointer favours req0.
  - All outputs 0.
  - Reset asserted mid-transfer abandons the word; no done pulse is produced.
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - reqN_ready is combinational: asserted only for the arbitration winner while its valid=1.
  - A single requester is always granted.
  - If both are valid, the requester not granted last wins; the pointer updates on acceptance.
  - On acceptance: latch data and requester id, go to CLEAR. At most one ready per cycle.
- CLEAR (1 cycle):
  - sr_clr=1.
  - Tick counter loaded to TICK_DIV-1, bit index=0.
  - Go to SHIFT.
- SHIFT:
  - Each cycle with hold=0: if counter≠0, decrement; else pulse sr_shift=1 with sr_si=data[bit index], reload counter to TICK_DIV-1, increment bit index.
  - hold=1 freezes counter and bit index, and suppresses sr_shift, even on the terminal count. Shifting resumes when hold drops.
  - After the WIDTH-th shift, go to DONE.
  - Bits go out LSB first, so that after WIDTH right-shifts reg[i]=data[i].
- DONE (1 cycle):
  - done=1, done_src=latched id.
  - Go to IDLE; a new request can be accepted the next cycle.
- Timing: if acceptance is sampled at edge 0, then:
  - sr_clr is high in cycle 1.
  - Shift k (k=1..WIDTH) occurs in cycle 1+k·TICK_DIV, with no hold.
  - done occurs in cycle 2+WIDTH·TICK_DIV.
- TICK_DIV=1: a shift every cycle during SHIFT.
- Requests that arrive while busy wait; ready stays 0. A valid that drops before acceptance is never latched.
- sr_si=0 whenever sr_shift=0.

Test Plan:
- Reset:
  - Stimulus: rst=0 mid-SHIFT with sr_shift due the next cycle.
  - Required: all outputs 0 immediately; no strobe.
  - After release: IDLE, and req0 wins a simultaneous request.
- Single word:
  - Stimulus: WIDTH=4, TICK_DIV=3, req0_data=4'b1011, accepted at edge 0.
  - Required: sr_clr in cycle 1.
  - Shifts in cycles 4,7,10,13 with sr_si=1,1,0,1.
  - done=1, done_src=0 in cycle 14; model register = 4'b1011.
- Arbitration:
  - Stimulus: both requesters valid continuously, data 4'hA / 4'h5.
  - Required: grants alternate req0, req1, req0.
  - Completed words are A,5,A; done_src=0,1,0.
- Busy blocking:
  - Stimulus: req1_valid rises in cycle 5 of a req0 transfer.
  - Required: req1_ready=0 until IDLE.
  - req1 is accepted the cycle after done.
- Hold:
  - Stimulus: TICK_DIV=3, hold=1 for cycles 6–9.
  - Required: no sr_shift during hold.
  - The second shift moves from cycle 7 to cycle 11; done is delayed by 4 cycles.
- TICK_DIV=1:
  - Stimulus: req0_data=4'b0110.
  - Required: shifts in cycles 2–5 with sr_si=0,1,1,0; done in cycle 6.

Source files
------------

// File: rtl/sipo_shift_sched_if.sv
// Requester-side handshake bundle for sipo_shift_sched: two valid/ready word
// channels. The master drives words; the slave (scheduler) returns ready.
interface sipo_shift_sched_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/sipo_shift_sched.sv
// Shares an external WIDTH-bit SIPO shift register between two requesters:
// round-robin word acceptance, register clear, LSB-first paced shifting, done pulse.
module sipo_shift_sched #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 100_000_000,
    parameter int CNT_W    = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_shift_sched_if.slave    req,
    input  logic                 hold,
    output logic                 sr_clr,
    output logic                 sr_shift,
    output logic                 sr_si,
    output logic                 busy,
    output logic                 done,
    output logic                 done_src
);

    localparam int                   IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]     TICK_LOAD = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg,   cnt_next;
    logic [IDX_W-1:0]   idx_reg,   idx_next;
    logic [WIDTH-1:0]   data_reg,  data_next;
    logic               src_reg,   src_next;
    logic               rr_reg,    rr_next;   // 0: req0 preferred on a tie
    logic               grant0, grant1;

    assign grant0 = req.req0_valid && (!req.req1_valid || !rr_reg);
    assign grant1 = req.req1_valid && (!req.req0_valid ||  rr_reg);
    assign busy   = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            src_reg   <= 1'b0;
            rr_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            src_reg   <= src_next;
            rr_reg    <= rr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        data_next      = data_reg;
        src_next       = src_reg;
        rr_next        = rr_reg;
        req.req0_ready = 1'b0;
        req.req1_ready = 1'b0;
        sr_clr         = 1'b0;
        sr_shift       = 1'b0;
        sr_si          = 1'b0;
        done           = 1'b0;
        done_src       = 1'b0;

        case (state_reg)
            IDLE: begin
                // ready is masked while reset is held so every output reads 0
                if (rst && (grant0 || grant1)) begin
                    req.req0_ready = grant0;
                    req.req1_ready = grant1;
                    data_next      = grant1 ? req.req1_data : req.req0_data;
                    src_next       = grant1;
                    rr_next        = !grant1;
                    state_next     = CLEAR;
                end
            end
            CLEAR: begin
                sr_clr     = 1'b1;
                cnt_next   = TICK_LOAD;
                idx_next   = '0;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (!hold) begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end else begin
                        sr_shift = 1'b1;
                        sr_si    = data_reg[idx_reg];
                        cnt_next = TICK_LOAD;
                        idx_next = idx_reg + IDX_W'(1);
                        if (idx_reg == LAST_IDX)
                            state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                done_src   = src_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
